// File: rtl/hazard_scoreboard.sv
// RAW hazard detector for the decode stage: a shift-register tracker of in-flight
// destination registers, a combinational stall request and a saturating stall counter.
module hazard_scoreboard #(
  parameter int REG_ADDR_LEN = 5,
  parameter int TRACK_DEPTH  = 3,
  parameter int FORWARD_EN   = 0,
  parameter int CNT_WIDTH    = 16
) (
  input  logic                    CLK,
  input  logic                    RST,
  input  logic                    ID_VALID,
  input  logic [REG_ADDR_LEN-1:0] ID_SRC1,
  input  logic [REG_ADDR_LEN-1:0] ID_SRC2,
  input  logic                    ID_TWO_SRC,
  input  logic [REG_ADDR_LEN-1:0] ID_DEST,
  input  logic                    ID_WB_EN,
  input  logic                    ID_MEM_READ,
  input  logic                    FLUSH,
  output logic                    HAZARD_DETECTED,
  output logic [CNT_WIDTH-1:0]    STALL_COUNT,
  output logic                    PIPE_BUSY
);

  localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

  logic [TRACK_DEPTH-1:0]  vld_q, vld_d;
  logic [TRACK_DEPTH-1:0]  wb_q, wb_d;
  logic [REG_ADDR_LEN-1:0] dest_q [TRACK_DEPTH];
  logic [REG_ADDR_LEN-1:0] dest_d [TRACK_DEPTH];
  // Load status only matters while the producer sits in EX, so only entry 0 keeps it.
  logic                    mr0_q, mr0_d;
  logic [CNT_WIDTH-1:0]    cnt_q, cnt_d;
  logic                    hit_all, hit_fwd, hit, accept;

  function automatic logic src_match(input logic                    v,
                                     input logic                    w,
                                     input logic [REG_ADDR_LEN-1:0] d,
                                     input logic [REG_ADDR_LEN-1:0] s);
    return v & w & (d == s) & (s != '0);
  endfunction

  always_comb begin
    hit_all = 1'b0;
    for (int k = 0; k < TRACK_DEPTH; k++) begin
      hit_all = hit_all
              | src_match(vld_q[k], wb_q[k], dest_q[k], ID_SRC1)
              | (ID_TWO_SRC & src_match(vld_q[k], wb_q[k], dest_q[k], ID_SRC2));
    end
    hit_fwd = mr0_q & (src_match(vld_q[0], wb_q[0], dest_q[0], ID_SRC1)
                     | (ID_TWO_SRC & src_match(vld_q[0], wb_q[0], dest_q[0], ID_SRC2)));
    hit     = (FORWARD_EN != 0) ? hit_fwd : hit_all;
  end

  assign HAZARD_DETECTED = ID_VALID & ~FLUSH & hit;
  assign accept          = ID_VALID & ~FLUSH & ~hit;
  assign PIPE_BUSY       = |vld_q;
  assign STALL_COUNT     = cnt_q;

  // Stalled or flushed instructions enter the tracker as an all-zero bubble.
  always_comb begin
    vld_d     = '0;
    wb_d      = '0;
    vld_d[0]  = accept;
    wb_d[0]   = accept & ID_WB_EN;
    mr0_d     = accept & ID_MEM_READ;
    dest_d[0] = accept ? ID_DEST : '0;
    for (int k = 1; k < TRACK_DEPTH; k++) begin
      vld_d[k]  = vld_q[k-1];
      wb_d[k]   = wb_q[k-1];
      dest_d[k] = dest_q[k-1];
    end
    cnt_d = cnt_q;
    if (HAZARD_DETECTED && (cnt_q != '1)) begin
      cnt_d = cnt_q + CNT_ONE;
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      vld_q <= '0;
      wb_q  <= '0;
      mr0_q <= 1'b0;
      cnt_q <= '0;
    end else begin
      vld_q <= vld_d;
      wb_q  <= wb_d;
      mr0_q <= mr0_d;
      cnt_q <= cnt_d;
    end
  end

  // Destination fields are qualified by valid, so they need no reset.
  always_ff @(posedge CLK) begin
    dest_q <= dest_d;
  end

endmodule
